// File: rtl/apb_cmd_pkg.sv
// Shared types and header/status field layout for the host-command APB initiator.
package apb_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_WDATA  = 3'd2,
        ST_SETUP  = 3'd3,
        ST_ACCESS = 3'd4,
        ST_RPUSH  = 3'd5,
        ST_STATUS = 3'd6
    } state_t;

    localparam int WR_BIT   = 31;
    localparam int CNT_MSB  = 27;
    localparam int CNT_LSB  = 24;
    localparam int ADDR_MSB = 23;

    localparam logic [7:0] STATUS_TAG = 8'hA5;

    // Status word: tag, error flag at bit 16, burst length-1, low start address bits.
    function automatic logic [31:0] status_word(input logic err,
                                                input logic [3:0] cnt,
                                                input logic [11:0] addr);
        return {STATUS_TAG, 7'h00, err, cnt, addr};
    endfunction

endpackage

// File: rtl/apb_xfer.sv
// Single APB transfer sequencer: SETUP then ACCESS, with a bounded wait for pready.
module apb_xfer #(
    parameter logic [7:0]  TIMEOUT     = 8'd255,
    parameter logic [31:0] RD_ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        write,
    input  logic [39:0] addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [39:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    logic        psel_r;
    logic        penable_r;
    logic        pwrite_r;
    logic [39:0] paddr_r;
    logic [31:0] pwdata_r;
    logic [7:0]  wait_cnt_r;
    logic        timeout_hit_s;

    assign psel    = psel_r;
    assign penable = penable_r;
    assign pwrite  = pwrite_r;
    assign paddr   = paddr_r;
    assign pwdata  = pwdata_r;

    // Completion and result selection; pready wins over a coincident timeout.
    always_comb begin
        timeout_hit_s = (wait_cnt_r == (TIMEOUT - 8'd1));
        if (psel_r && penable_r && (pready || timeout_hit_s)) begin
            done = 1'b1;
        end else begin
            done = 1'b0;
        end
        if (pready) begin
            rdata = prdata;
            err   = pslverr;
        end else begin
            rdata = RD_ERR_DATA;
            err   = 1'b1;
        end
    end

    // APB phase registers; address/data are frozen from start until completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            psel_r     <= 1'b0;
            penable_r  <= 1'b0;
            pwrite_r   <= 1'b0;
            paddr_r    <= 40'h0;
            pwdata_r   <= 32'h0;
            wait_cnt_r <= 8'd0;
        end else if (start) begin
            psel_r     <= 1'b1;
            penable_r  <= 1'b0;
            pwrite_r   <= write;
            paddr_r    <= addr;
            pwdata_r   <= write ? wdata : 32'h0;
            wait_cnt_r <= 8'd0;
        end else if (psel_r && !penable_r) begin
            penable_r <= 1'b1;
        end else if (penable_r) begin
            if (done) begin
                psel_r    <= 1'b0;
                penable_r <= 1'b0;
            end else begin
                wait_cnt_r <= wait_cnt_r + 8'd1;
            end
        end else begin
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
        end
    end

endmodule

// File: rtl/apb_cmd_master.sv
// Host-command APB initiator: pops burst commands from the USB receive FIFO,
// runs the APB transfers and returns read data plus a status word.
module apb_cmd_master
    import apb_cmd_pkg::*;
#(
    parameter logic [39:0] BASE_ADDR   = 40'h00_A000_0000,
    parameter logic [7:0]  TIMEOUT     = 8'd255,
    parameter logic [31:0] RD_ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] cmd_data,
    input  logic        cmd_empty,
    output logic        cmd_rd_en,
    output logic [31:0] rsp_data,
    output logic        rsp_wr_en,
    input  logic        rsp_full,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [39:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr,
    output logic        busy
);

    state_t      state_r;
    logic        hdr_write_r;
    logic [3:0]  hdr_cnt_r;
    logic [23:0] hdr_addr_r;
    logic [23:0] addr_r;
    logic [3:0]  words_left_r;
    logic        last_r;
    logic        err_r;
    logic        cmd_rd_en_r;
    logic        rsp_wr_en_r;
    logic [31:0] rsp_data_r;
    logic        busy_r;

    logic        start_s;
    logic [23:0] addr_sel_s;
    logic [39:0] xfer_addr_s;
    logic        xfer_done_s;
    logic [31:0] xfer_rdata_s;
    logic        xfer_err_s;

    assign cmd_rd_en = cmd_rd_en_r;
    assign rsp_wr_en = rsp_wr_en_r;
    assign rsp_data  = rsp_data_r;
    assign busy      = busy_r;

    // Launch a transfer on the same edge the FSM enters SETUP.
    always_comb begin
        start_s    = 1'b0;
        addr_sel_s = addr_r;
        case (state_r)
            ST_HDR: begin
                addr_sel_s = hdr_addr_r;
                if (!hdr_write_r && !rsp_full) begin
                    start_s = 1'b1;
                end else begin
                    start_s = 1'b0;
                end
            end
            ST_WDATA: begin
                if (!cmd_empty) begin
                    start_s = 1'b1;
                end else begin
                    start_s = 1'b0;
                end
            end
            ST_RPUSH: start_s = rsp_wr_en_r & ~last_r;
            default:  start_s = 1'b0;
        endcase
        xfer_addr_s = BASE_ADDR | {16'h0000, addr_sel_s};
    end

    apb_xfer #(
        .TIMEOUT     (TIMEOUT),
        .RD_ERR_DATA (RD_ERR_DATA)
    ) u_xfer (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start_s),
        .write   (hdr_write_r),
        .addr    (xfer_addr_s),
        .wdata   (cmd_data),
        .done    (xfer_done_s),
        .rdata   (xfer_rdata_s),
        .err     (xfer_err_s),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    // Command/response FSM; response pushes are strobed in the RPUSH/STATUS cycle itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            hdr_write_r  <= 1'b0;
            hdr_cnt_r    <= 4'd0;
            hdr_addr_r   <= 24'h0;
            addr_r       <= 24'h0;
            words_left_r <= 4'd0;
            last_r       <= 1'b0;
            err_r        <= 1'b0;
            cmd_rd_en_r  <= 1'b0;
            rsp_wr_en_r  <= 1'b0;
            rsp_data_r   <= 32'h0;
            busy_r       <= 1'b0;
        end else begin
            cmd_rd_en_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    rsp_wr_en_r <= 1'b0;
                    if (!cmd_empty) begin
                        hdr_write_r <= cmd_data[WR_BIT];
                        hdr_cnt_r   <= cmd_data[CNT_MSB:CNT_LSB];
                        hdr_addr_r  <= {cmd_data[ADDR_MSB:2], 2'b00};
                        cmd_rd_en_r <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= ST_HDR;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_HDR: begin
                    addr_r       <= hdr_addr_r;
                    words_left_r <= hdr_cnt_r;
                    err_r        <= 1'b0;
                    if (hdr_write_r) begin
                        state_r <= ST_WDATA;
                    end else if (start_s) begin
                        state_r <= ST_SETUP;
                    end
                end
                ST_WDATA: begin
                    if (start_s) begin
                        cmd_rd_en_r <= 1'b1;
                        state_r     <= ST_SETUP;
                    end
                end
                ST_SETUP: state_r <= ST_ACCESS;
                ST_ACCESS: begin
                    if (xfer_done_s) begin
                        err_r  <= err_r | xfer_err_s;
                        addr_r <= addr_r + 24'd4;
                        last_r <= (words_left_r == 4'd0);
                        if (words_left_r != 4'd0) begin
                            words_left_r <= words_left_r - 4'd1;
                        end
                        if (!hdr_write_r) begin
                            rsp_data_r  <= xfer_rdata_s;
                            rsp_wr_en_r <= ~rsp_full;
                            state_r     <= ST_RPUSH;
                        end else if (words_left_r != 4'd0) begin
                            state_r <= ST_WDATA;
                        end else begin
                            rsp_data_r  <= status_word(err_r | xfer_err_s, hdr_cnt_r, hdr_addr_r[11:0]);
                            rsp_wr_en_r <= ~rsp_full;
                            state_r     <= ST_STATUS;
                        end
                    end
                end
                ST_RPUSH: begin
                    if (rsp_wr_en_r) begin
                        rsp_wr_en_r <= 1'b0;
                        if (last_r) begin
                            rsp_data_r <= status_word(err_r, hdr_cnt_r, hdr_addr_r[11:0]);
                            state_r    <= ST_STATUS;
                        end else begin
                            state_r <= ST_SETUP;
                        end
                    end else if (!rsp_full) begin
                        rsp_wr_en_r <= 1'b1;
                    end
                end
                ST_STATUS: begin
                    if (rsp_wr_en_r) begin
                        rsp_wr_en_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else if (!rsp_full) begin
                        rsp_wr_en_r <= 1'b1;
                    end
                end
                default: begin
                    rsp_wr_en_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: FIFO and APB slave models advanced one cycle at a time.
module tb_apb_cmd_master;

    localparam logic [39:0] BASE = 40'h00_A000_0000;

    logic        clk;
    logic        reset_n;
    logic [31:0] cmd_data;
    logic        cmd_empty;
    logic        cmd_rd_en;
    logic [31:0] rsp_data;
    logic        rsp_wr_en;
    logic        rsp_full;
    logic        psel, penable, pwrite;
    logic [39:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        busy;

    apb_cmd_master #(
        .BASE_ADDR   (BASE),
        .TIMEOUT     (8'd8),
        .RD_ERR_DATA (32'hDEADBEEF)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_data  (cmd_data),
        .cmd_empty (cmd_empty),
        .cmd_rd_en (cmd_rd_en),
        .rsp_data  (rsp_data),
        .rsp_wr_en (rsp_wr_en),
        .rsp_full  (rsp_full),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int chk_cnt;
    int pass_cnt;

    logic [31:0] cmd_q[$];
    logic [31:0] rsp_log[$];
    logic [31:0] rd_vals[$];
    logic [39:0] apb_addr[$];
    logic [31:0] apb_wdata[$];
    logic        apb_write[$];

    int   setup_cnt, acc, last_acc, stable_err, proto_err, rd_idx, ready_delay;
    bit   stuck, slverr_flag;
    logic [39:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_write;

    task automatic clear_logs();
        rsp_log.delete();
        apb_addr.delete();
        apb_wdata.delete();
        apb_write.delete();
        rd_vals.delete();
        setup_cnt = 0; last_acc = 0; stable_err = 0; proto_err = 0; rd_idx = 0;
        ready_delay = 0; stuck = 1'b0; slverr_flag = 1'b0;
    endtask

    // One clock: observe DUT at the falling edge, update FIFO and slave models.
    task automatic step();
        @(negedge clk);
        if (cmd_rd_en && cmd_q.size() > 0) void'(cmd_q.pop_front());
        if (rsp_wr_en) rsp_log.push_back(rsp_data);
        if (penable && !psel) proto_err++;
        if (psel && !penable) begin
            setup_cnt++;
            s_addr = paddr; s_wdata = pwdata; s_write = pwrite;
        end
        if (psel && penable) begin
            if (paddr !== s_addr || pwdata !== s_wdata || pwrite !== s_write) stable_err++;
            acc++;
            last_acc = acc;
            if (!stuck && acc > ready_delay) begin
                pready  = 1'b1;
                pslverr = slverr_flag;
                prdata  = (rd_idx < rd_vals.size()) ? rd_vals[rd_idx] : 32'h0;
                apb_addr.push_back(paddr);
                apb_wdata.push_back(pwdata);
                apb_write.push_back(pwrite);
                rd_idx++;
            end else begin
                pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
            end
        end else begin
            acc = 0; pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
        end
        cmd_empty = (cmd_q.size() == 0);
        cmd_data  = cmd_empty ? 32'h0 : cmd_q[0];
    endtask

    task automatic wait_done(input int max, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < max; n++) begin
            step();
            if (!busy && cmd_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        chk_cnt++; if (psel !== 1'b0)      $display("FAIL rst_psel: got %b want 0", psel); else pass_cnt++;
        chk_cnt++; if (penable !== 1'b0)   $display("FAIL rst_penable: got %b want 0", penable); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0)      $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (cmd_rd_en !== 1'b0) $display("FAIL rst_cmd_rd_en: got %b want 0", cmd_rd_en); else pass_cnt++;
        chk_cnt++; if (rsp_wr_en !== 1'b0) $display("FAIL rst_rsp_wr_en: got %b want 0", rsp_wr_en); else pass_cnt++;
        chk_cnt++; if (paddr !== 40'h0)    $display("FAIL rst_paddr: got %h want 0", paddr); else pass_cnt++;
        reset_n = 1'b1;
        repeat (2) step();
        chk_cnt++; if (busy !== 1'b0)      $display("FAIL idle_busy: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_write_burst();
        bit ok;
        clear_logs();
        cmd_q.push_back(32'h8100_0010); cmd_q.push_back(32'h1); cmd_q.push_back(32'h2);
        wait_done(100, ok);
        chk_cnt++; if (ok !== 1'b1) $display("FAIL wr_done: got %b want 1", ok); else pass_cnt++;
        chk_cnt++; if (apb_addr.size() !== 2) $display("FAIL wr_xfers: got %0d want 2", apb_addr.size()); else pass_cnt++;
        chk_cnt++; if (apb_addr[0] !== (BASE | 40'h10) || apb_wdata[0] !== 32'h1 || apb_write[0] !== 1'b1)
            $display("FAIL wr_xfer0: got %h/%h/%b want %h/1/1", apb_addr[0], apb_wdata[0], apb_write[0], BASE | 40'h10); else pass_cnt++;
        chk_cnt++; if (apb_addr[1] !== (BASE | 40'h14) || apb_wdata[1] !== 32'h2 || apb_write[1] !== 1'b1)
            $display("FAIL wr_xfer1: got %h/%h/%b want %h/2/1", apb_addr[1], apb_wdata[1], apb_write[1], BASE | 40'h14); else pass_cnt++;
        chk_cnt++; if (setup_cnt !== 2) $display("FAIL wr_setups: got %0d want 2", setup_cnt); else pass_cnt++;
        chk_cnt++; if (rsp_log.size() !== 1 || rsp_log[0] !== 32'hA500_1010)
            $display("FAIL wr_status: got %0d words, first %h want 1 word A5001010", rsp_log.size(), rsp_log[0]); else pass_cnt++;
        chk_cnt++; if (stable_err !== 0 || proto_err !== 0)
            $display("FAIL wr_stable: got %0d/%0d want 0/0", stable_err, proto_err); else pass_cnt++;
    endtask

    task automatic test_read_burst();
        bit ok;
        logic [31:0] exp_rsp[$];
        logic [39:0] exp_addr[$];
        clear_logs();
        rd_vals = '{32'h11, 32'h22, 32'h33};
        ready_delay = 2;
        exp_rsp  = '{32'h11, 32'h22, 32'h33, 32'hA500_200C};
        exp_addr = '{BASE | 40'h0C, BASE | 40'h10, BASE | 40'h14};
        cmd_q.push_back(32'h0200_000C);
        wait_done(200, ok);
        chk_cnt++; if (ok !== 1'b1) $display("FAIL rd_done: got %b want 1", ok); else pass_cnt++;
        chk_cnt++; if (rsp_log.size() !== 4) $display("FAIL rd_count: got %0d want 4", rsp_log.size()); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            chk_cnt++; if (rsp_log[i] !== exp_rsp[i]) $display("FAIL rd_rsp%0d: got %h want %h", i, rsp_log[i], exp_rsp[i]); else pass_cnt++;
        end
        for (int i = 0; i < 3; i++) begin
            chk_cnt++; if (apb_addr[i] !== exp_addr[i] || apb_write[i] !== 1'b0)
                $display("FAIL rd_addr%0d: got %h/%b want %h/0", i, apb_addr[i], apb_write[i], exp_addr[i]); else pass_cnt++;
        end
        chk_cnt++; if (setup_cnt !== 3 || stable_err !== 0) $display("FAIL rd_setups: got %0d/%0d want 3/0", setup_cnt, stable_err); else pass_cnt++;
    endtask

    task automatic test_timeout();
        bit ok;
        clear_logs();
        stuck = 1'b1;
        cmd_q.push_back(32'h0000_0040);
        wait_done(100, ok);
        chk_cnt++; if (ok !== 1'b1) $display("FAIL to_done: got %b want 1", ok); else pass_cnt++;
        chk_cnt++; if (last_acc !== 8) $display("FAIL to_access_cycles: got %0d want 8", last_acc); else pass_cnt++;
        chk_cnt++; if (rsp_log.size() !== 2 || rsp_log[0] !== 32'hDEADBEEF)
            $display("FAIL to_data: got %0d words, first %h want 2 words, DEADBEEF", rsp_log.size(), rsp_log[0]); else pass_cnt++;
        chk_cnt++; if (rsp_log[1] !== 32'hA501_0040) $display("FAIL to_status: got %h want A5010040", rsp_log[1]); else pass_cnt++;
    endtask

    task automatic test_pslverr();
        bit ok;
        clear_logs();
        slverr_flag = 1'b1;
        cmd_q.push_back(32'h8000_0020); cmd_q.push_back(32'h5);
        wait_done(100, ok);
        chk_cnt++; if (ok !== 1'b1 || rsp_log.size() !== 1 || rsp_log[0] !== 32'hA501_0020)
            $display("FAIL slverr_status: got %b/%0d/%h want 1/1/A5010020", ok, rsp_log.size(), rsp_log[0]); else pass_cnt++;
        clear_logs();
        cmd_q.push_back(32'h8000_0024); cmd_q.push_back(32'h6);
        wait_done(100, ok);
        chk_cnt++; if (ok !== 1'b1 || rsp_log.size() !== 1 || rsp_log[0] !== 32'hA500_0024)
            $display("FAIL slverr_cleared: got %b/%0d/%h want 1/1/A5000024", ok, rsp_log.size(), rsp_log[0]); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        bit ok;
        int n;
        clear_logs();
        rd_vals = '{32'hA1, 32'hA2};
        cmd_q.push_back(32'h0100_0080);
        n = 0;
        while (setup_cnt == 0 && n < 20) begin step(); n++; end
        chk_cnt++; if (setup_cnt !== 1) $display("FAIL bp_first_setup: got %0d want 1", setup_cnt); else pass_cnt++;
        rsp_full = 1'b1;
        repeat (10) step();
        chk_cnt++; if (setup_cnt !== 1) $display("FAIL bp_no_second_setup: got %0d want 1", setup_cnt); else pass_cnt++;
        chk_cnt++; if (rsp_log.size() !== 0) $display("FAIL bp_no_push: got %0d want 0", rsp_log.size()); else pass_cnt++;
        rsp_full = 1'b0;
        wait_done(100, ok);
        chk_cnt++; if (ok !== 1'b1 || rsp_log.size() !== 3) $display("FAIL bp_count: got %b/%0d want 1/3", ok, rsp_log.size()); else pass_cnt++;
        chk_cnt++; if (rsp_log[0] !== 32'hA1 || rsp_log[1] !== 32'hA2 || rsp_log[2] !== 32'hA500_1080)
            $display("FAIL bp_data: got %h %h %h want A1 A2 A5001080", rsp_log[0], rsp_log[1], rsp_log[2]); else pass_cnt++;
    endtask

    task automatic test_starvation();
        bit ok;
        bit psel_seen;
        clear_logs();
        psel_seen = 1'b0;
        cmd_q.push_back(32'h8000_0100);
        repeat (10) begin step(); psel_seen |= psel; end
        chk_cnt++; if (psel_seen !== 1'b0 || busy !== 1'b1)
            $display("FAIL starve_hold: got psel_seen=%b busy=%b want 0/1", psel_seen, busy); else pass_cnt++;
        cmd_q.push_back(32'h77);
        wait_done(100, ok);
        chk_cnt++; if (ok !== 1'b1 || apb_addr.size() !== 1 || apb_addr[0] !== (BASE | 40'h100) || apb_wdata[0] !== 32'h77)
            $display("FAIL starve_write: got %b/%0d/%h/%h want 1/1/%h/77", ok, apb_addr.size(), apb_addr[0], apb_wdata[0], BASE | 40'h100); else pass_cnt++;
        chk_cnt++; if (rsp_log.size() !== 1 || rsp_log[0] !== 32'hA500_0100)
            $display("FAIL starve_status: got %0d/%h want 1/A5000100", rsp_log.size(), rsp_log[0]); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        clear_logs();
        stuck = 1'b1;
        cmd_q.push_back(32'h0000_0200);
        n = 0;
        while (!(psel && penable) && n < 20) begin step(); n++; end
        chk_cnt++; if (!(psel && penable)) $display("FAIL rm_reach_access: got %b%b want 11", psel, penable); else pass_cnt++;
        reset_n = 1'b0;
        #1;
        chk_cnt++; if ({psel, penable, busy, cmd_rd_en, rsp_wr_en} !== 5'b0)
            $display("FAIL rm_async_clear: got %b want 00000", {psel, penable, busy, cmd_rd_en, rsp_wr_en}); else pass_cnt++;
        repeat (2) step();
        cmd_q.delete();
        clear_logs();
        reset_n = 1'b1;
        rd_vals = '{32'h55};
        cmd_q.push_back(32'h0000_0044);
        wait_done(100, ok);
        chk_cnt++; if (ok !== 1'b1 || rsp_log.size() !== 2 || rsp_log[0] !== 32'h55 || rsp_log[1] !== 32'hA500_0044)
            $display("FAIL rm_recover: got %b/%0d/%h/%h want 1/2/55/A5000044", ok, rsp_log.size(), rsp_log[0], rsp_log[1]); else pass_cnt++;
    endtask

    initial begin
        chk_cnt = 0; pass_cnt = 0;
        cmd_data = 32'h0; cmd_empty = 1'b1; rsp_full = 1'b0;
        prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
        acc = 0; s_addr = 40'h0; s_wdata = 32'h0; s_write = 1'b0;
        clear_logs();
        test_reset();
        test_write_burst();
        test_read_burst();
        test_timeout();
        test_pslverr();
        test_backpressure();
        test_starvation();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
